// File: rtl/cav4_freq_slew_pkg.sv
// Shared widths, fine-path limits and FSM state type for the cav4 frequency slew block.
package cav4_freq_slew_pkg;

  localparam int unsigned FREQ_W = 28;
  localparam int unsigned FINE_W = 18;
  localparam int unsigned STEP_W = 16;
  // Differences of two FREQ_W values need one extra bit to avoid wrap.
  localparam int unsigned DIFF_W = FREQ_W + 1;

  localparam logic signed [FINE_W-1:0] FINE_MAX = {1'b0, {(FINE_W-1){1'b1}}};
  localparam logic signed [FINE_W-1:0] FINE_MIN = {1'b1, {(FINE_W-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    SLEW = 1'b1
  } state_e;

endpackage

// File: rtl/cav4_freq_slew_if.sv
// Target handshake and coarse/fine output bundle of cav4_freq_slew.
interface cav4_freq_slew_if;
  import cav4_freq_slew_pkg::*;

  logic signed [FREQ_W-1:0] target;
  logic        [STEP_W-1:0] step;
  logic                     target_valid;
  logic                     target_ready;
  logic signed [FREQ_W-1:0] coarse_freq;
  logic signed [FINE_W-1:0] fine;
  logic                     fine_sat;
  logic                     busy;
  logic                     done;

  // Host side: offers targets, observes the generated frequency pair.
  modport master (
    output target, step, target_valid,
    input  target_ready, coarse_freq, fine, fine_sat, busy, done
  );

  // Slew engine side.
  modport slave (
    input  target, step, target_valid,
    output target_ready, coarse_freq, fine, fine_sat, busy, done
  );

endinterface

// File: rtl/cav4_freq_sat.sv
// Signed 29-bit to 18-bit saturator with clip flag, shared by fine-frequency paths.
module cav4_freq_sat
  import cav4_freq_slew_pkg::*;
(
  input  logic signed [DIFF_W-1:0] i_val,
  output logic signed [FINE_W-1:0] o_val,
  output logic                     o_sat
);

  // Value fits when all bits above the fine sign bit match that sign bit.
  logic [DIFF_W-FINE_W:0] w_top;
  assign w_top = i_val[DIFF_W-1:FINE_W-1];

  // Clip to the fine range, picking the rail from the input sign.
  always_comb begin
    o_sat = !((&w_top) || !(|w_top));
    o_val = i_val[FINE_W-1:0];
    if (o_sat) begin
      o_val = i_val[DIFF_W-1] ? FINE_MIN : FINE_MAX;
    end
  end

endmodule

// File: rtl/cav4_freq_slew.sv
// Rate-limited coarse frequency slew with saturated fine residual.
// Optional feature macro: CAV4_FREQ_RETARGET_EN (accept new targets while slewing).
module cav4_freq_slew
  import cav4_freq_slew_pkg::*;
#(
  parameter int unsigned DF_SCALE = 2,
  parameter int unsigned STEP_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  cav4_freq_slew_if.slave  bus
);

  localparam int unsigned SHIFT = DF_SCALE - 2;
  localparam logic [STEP_W-1:0] TICK_LAST = STEP_W'(STEP_DIV - 1);

  state_e                   r_state;
  logic signed [FREQ_W-1:0] r_target;
  logic        [STEP_W-1:0] r_step;
  logic        [STEP_W-1:0] r_cnt;
  logic signed [FREQ_W-1:0] r_coarse;
  logic signed [FINE_W-1:0] r_fine;
  logic                     r_fine_sat;
  logic                     r_done;

  logic                     w_ready;
  logic                     w_accept;
  logic                     w_tick;
  logic                     w_land;
  logic signed [DIFF_W-1:0] w_coarse_ext;
  logic signed [DIFF_W-1:0] w_target_ext;
  logic signed [DIFF_W-1:0] w_step_ext;
  logic signed [DIFF_W-1:0] w_diff;
  logic        [DIFF_W-1:0] w_abs;
  logic signed [DIFF_W-1:0] w_stepped;
  logic signed [FREQ_W-1:0] w_coarse_next;
  logic signed [DIFF_W-1:0] w_src_ext;
  logic signed [DIFF_W-1:0] w_next_ext;
  logic signed [DIFF_W-1:0] w_fine_diff;
  logic signed [DIFF_W-1:0] w_fine_shift;
  logic signed [FINE_W-1:0] w_fine;
  logic                     w_fine_sat;

`ifdef CAV4_FREQ_RETARGET_EN
  assign w_ready = 1'b1;
`else
  assign w_ready = (r_state == IDLE);
`endif

  assign w_accept = bus.target_valid && w_ready;
  assign w_tick   = (r_state == SLEW) && (r_cnt == TICK_LAST);

  // Step decision: land on the target or move one step toward it without overshoot.
  always_comb begin
    w_coarse_ext  = {r_coarse[FREQ_W-1], r_coarse};
    w_target_ext  = {r_target[FREQ_W-1], r_target};
    w_step_ext    = {{(DIFF_W-STEP_W){1'b0}}, r_step};
    w_diff        = w_target_ext - w_coarse_ext;
    w_abs         = w_diff[DIFF_W-1] ? -w_diff : w_diff;
    w_land        = (r_step == '0) || (w_abs <= DIFF_W'(r_step));
    w_stepped     = w_diff[DIFF_W-1] ? (w_coarse_ext - w_step_ext) : (w_coarse_ext + w_step_ext);
    w_coarse_next = r_coarse;
    if (!w_accept && w_tick) begin
      w_coarse_next = w_land ? r_target : w_stepped[FREQ_W-1:0];
    end
  end

  // Fine residual against whichever target is in force after this edge.
  always_comb begin
    w_src_ext    = w_accept ? {bus.target[FREQ_W-1], bus.target} : w_target_ext;
    w_next_ext   = {w_coarse_next[FREQ_W-1], w_coarse_next};
    w_fine_diff  = w_src_ext - w_next_ext;
    w_fine_shift = w_fine_diff >>> SHIFT;
  end

  cav4_freq_sat u_sat (
    .i_val (w_fine_shift),
    .o_val (w_fine),
    .o_sat (w_fine_sat)
  );

  // Slew FSM: a handshake always wins over a step that lands in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_target   <= '0;
      r_step     <= '0;
      r_cnt      <= '0;
      r_coarse   <= '0;
      r_fine     <= '0;
      r_fine_sat <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_target   <= bus.target;
        r_step     <= bus.step;
        r_cnt      <= '0;
        r_fine     <= w_fine;
        r_fine_sat <= w_fine_sat;
        r_state    <= SLEW;
      end else if (r_state == SLEW) begin
        if (w_tick) begin
          r_cnt      <= '0;
          r_coarse   <= w_coarse_next;
          r_fine     <= w_fine;
          r_fine_sat <= w_fine_sat;
          if (w_land) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.target_ready = w_ready;
  assign bus.busy         = (r_state == SLEW);
  assign bus.coarse_freq  = r_coarse;
  assign bus.fine         = r_fine;
  assign bus.fine_sat     = r_fine_sat;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_cav4_freq_slew.sv
// Self-checking bench for cav4_freq_slew: directed scenarios plus randomized targets
// against an arithmetic reference model.
module tb_cav4_freq_slew;

  localparam int unsigned DF_SCALE = 2;
  localparam int unsigned STEP_DIV = 4;
`ifdef CAV4_FREQ_RETARGET_EN
  localparam bit RETARGET = 1'b1;
`else
  localparam bit RETARGET = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cav4_freq_slew_if bus ();

  cav4_freq_slew #(
    .DF_SCALE (DF_SCALE),
    .STEP_DIV (STEP_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: frequency the combiner's coarse input should hold, active request.
  longint m_coarse = 0;
  longint m_target = 0;
  longint m_step   = 0;
  int     m_cyc    = 0;
  bit     got_done;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_fine_raw(input longint t, input longint c);
    return (t - c) >>> (DF_SCALE - 2);
  endfunction

  function automatic longint ref_fine(input longint t, input longint c);
    longint r = ref_fine_raw(t, c);
    if (r > 131071)  return 131071;
    if (r < -131072) return -131072;
    return r;
  endfunction

  function automatic longint ref_next(input longint c, input longint t, input longint s);
    longint d = t - c;
    longint a = (d < 0) ? -d : d;
    if (s == 0 || a <= s) return t;
    return (d > 0) ? c + s : c - s;
  endfunction

  task automatic check_outputs(input string tag, input bit exp_done);
    check({tag, ".coarse"}, bus.coarse_freq, 32'(m_coarse));
    check({tag, ".fine"}, bus.fine, 32'(ref_fine(m_target, m_coarse)));
    check({tag, ".fine_sat"}, bus.fine_sat,
          32'(ref_fine(m_target, m_coarse) != ref_fine_raw(m_target, m_coarse)));
    check({tag, ".done"}, bus.done, 32'(exp_done));
    check({tag, ".busy"}, bus.busy, 32'(!exp_done));
    check({tag, ".ready"}, bus.target_ready, 32'(exp_done || RETARGET));
  endtask

  // Offer one request; it must be taken on the next edge.
  task automatic accept(input longint t, input longint s);
    @(negedge clk);
    bus.target       = 28'(t);
    bus.step         = 16'(s);
    bus.target_valid = 1'b1;
    @(posedge clk);
    #1;
    m_target = t;
    m_step   = s;
    m_cyc    = 0;
    check_outputs("accept", 1'b0);
  endtask

  // Follow the slew cycle by cycle for up to max_cyc edges or until completion.
  task automatic slew(input int max_cyc, input bit drop_valid);
    got_done = 1'b0;
    for (int i = 0; i < max_cyc && !got_done; i++) begin
      @(negedge clk);
      if (drop_valid) bus.target_valid = 1'b0;
      @(posedge clk);
      #1;
      m_cyc++;
      if (m_cyc % STEP_DIV == 0) begin
        m_coarse = ref_next(m_coarse, m_target, m_step);
        got_done = (m_coarse == m_target);
      end
      check_outputs("slew", got_done);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_coarse = 0;
    m_target = 0;
    m_step   = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    longint t, s, off;
    bus.target       = '0;
    bus.step         = '0;
    bus.target_valid = 1'b0;

    // Reset state.
    #12;
    check("rst.ready", bus.target_ready, 1);
    check("rst.coarse", bus.coarse_freq, 0);
    check("rst.fine", bus.fine, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    rst_n = 1'b1;

    // Basic ramp 0 -> 1000 in steps of 300.
    accept(1000, 300);
    check("ramp.fine0", bus.fine, 1000);
    slew(40, 1'b1);
    check("ramp.got_done", 32'(got_done), 1);
    check("ramp.final", bus.coarse_freq, 1000);
    check("ramp.cycles", m_cyc, 16);

    // Large negative target, fine saturates until the second step.
    do_reset();
    accept(-200000, 65535);
    check("neg.fine0", bus.fine, -131072);
    check("neg.sat0", bus.fine_sat, 1);
    slew(40, 1'b1);
    check("neg.got_done", 32'(got_done), 1);
    check("neg.final", bus.coarse_freq, -200000);

    // step = 0 jumps on the first tick.
    do_reset();
    accept(12345, 0);
    slew(40, 1'b1);
    check("jump.got_done", 32'(got_done), 1);
    check("jump.cycles", m_cyc, STEP_DIV);
    check("jump.fine", bus.fine, 0);

    // Target equal to current coarse still completes on the first tick.
    accept(12345, 10);
    slew(40, 1'b1);
    check("same.cycles", m_cyc, STEP_DIV);

    if (!RETARGET) begin
      // A held request during SLEW is ignored, then taken the cycle after done.
      accept(12845, 200);
      bus.target = 28'(-500);
      bus.step   = 16'(1000);
      slew(40, 1'b0);
      check("hold.got_done", 32'(got_done), 1);
      check("hold.coarse_a", bus.coarse_freq, 12845);
      @(posedge clk);
      #1;
      m_target = -500;
      m_step   = 1000;
      m_cyc    = 0;
      check_outputs("hold.accept_b", 1'b0);
      slew(80, 1'b1);
      check("hold.got_done_b", 32'(got_done), 1);
    end else begin
      // Retarget to 0 at coarse 600 mid-ramp to 1000 reverses the ramp.
      do_reset();
      accept(1000, 300);
      slew(8, 1'b1);
      check("rt.mid", bus.coarse_freq, 600);
      check("rt.mid_done", 32'(got_done), 0);
      accept(0, 300);
      check("rt.fine", bus.fine, -600);
      slew(40, 1'b1);
      check("rt.got_done", 32'(got_done), 1);
      check("rt.cycles", m_cyc, 2 * STEP_DIV);
      check("rt.final", bus.coarse_freq, 0);
    end

    // Asynchronous reset mid-slew clears everything without a done pulse.
    accept(m_coarse + 5000, 700);
    slew(6, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst.coarse", bus.coarse_freq, 0);
    check("arst.fine", bus.fine, 0);
    check("arst.busy", bus.busy, 0);
    check("arst.done", bus.done, 0);
    m_coarse = 0;
    m_target = 0;
    m_step   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * STEP_DIV; i++) begin
      @(posedge clk);
      #1;
      check("arst.ready", bus.target_ready, 1);
      check("arst.no_done", bus.done, 0);
    end

    // Randomized requests relative to the current coarse frequency.
    for (int n = 0; n < 16; n++) begin
      s   = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom_range(1, 65535));
      off = longint'($urandom_range(0, 12)) * s + longint'($urandom_range(0, 1000));
      if (s == 0) off = longint'($urandom_range(0, 500000));
      if ($urandom_range(0, 9) == 0) off = 0;
      t = ($urandom_range(0, 1) == 1) ? m_coarse + off : m_coarse - off;
      accept(t, s);
      slew(200, 1'b1);
      check("rand.got_done", 32'(got_done), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cav4_freq_slew.md
Name: cav4_freq_slew

Overview:
- Inverse companion of the cavity frequency combiner: it generates the coarse/fine frequency pair that the combiner sums.
- Accepts a 28-bit total detune target over a valid/ready handshake.
- Slews `coarse_freq` toward the target in rate-limited steps; `fine` carries the saturated residual, so combiner output approaches the target immediately within fine range.
- Sits between the host register map and the cavity electrical model.

Parameters:
- DF_SCALE, 2, fine-path shift used by the downstream combiner; legal range 2..9.
- STEP_DIV, 4, clock cycles between coarse steps; legal range 1..65535.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- target  in  28  signed total detune request
- step  in  16  unsigned max coarse change per step; 0 means jump in one step
- target_valid  in  1  target/step offered
- target_ready  out  1  target/step may be accepted this cycle
- coarse_freq  out  28  signed coarse frequency to combiner
- fine  out  18  signed fine residual to combiner
- fine_sat  out  1  fine is clipped this cycle
- busy  out  1  slew in progress
- done  out  1  one-cycle pulse when coarse_freq reaches target

Behaviour:
- Reset (async assert, sync-safe release): all outputs, `target_r`, `step_r` and tick counter go to 0; state IDLE.
  - `target_ready` reads 1 after reset, since it is combinational from state.
  - Reset mid-slew abandons the slew; no `done` pulse.
- States: IDLE, SLEW.
- IDLE:
  - `target_ready`=1, `busy`=0.
  - On `target_valid`&`target_ready`: latch `target_r`←`target`, `step_r`←`step`; clear tick counter; `fine`←sat18((`target`−`coarse_freq`)>>>(DF_SCALE−2)); go SLEW.
  - If `target` equals `coarse_freq`, still enter SLEW; the first tick completes it.
- SLEW:
  - `busy`=1, `target_ready`=0.
  - Tick counter increments each cycle; at count STEP_DIV−1 it wraps to 0 and a step occurs.
  - Step, with diff=`target_r`−`coarse_freq` computed in 29 bits (no wrap):
    - If `step_r`==0 or |diff|≤`step_r`: `coarse_freq`←`target_r`, `fine`←0, `fine_sat`←0, `done`←1 for one cycle, go IDLE.
    - Else `coarse_freq`←`coarse_freq`±`step_r`, moving toward the target.
    - `fine` and `fine_sat` are recomputed from the new `coarse_freq` on the same edge.
- Latency: accept on edge k. First step on edge k+STEP_DIV; subsequent steps every STEP_DIV cycles.
- Saturation:
  - sat18 clips to [−131072, 131071].
  - `fine_sat`=1 exactly when clipping occurred, registered with `fine`.
- Arithmetic:
  - `coarse_freq` never overshoots `target_r`.
  - Step magnitude is zero-extended to 29 bits before add/subtract.
- `target_valid` while not ready: ignored; the source must hold.

Optional Feature:
- CAV4_FREQ_RETARGET_EN.
- Defined:
  - `target_ready`=1 in SLEW as well.
  - A handshake in SLEW reloads `target_r`/`step_r`, clears the tick counter, and recomputes `fine` against the current `coarse_freq`.
  - If the handshake coincides with a completing step, the new target wins: no `done`, state stays SLEW.
- Undefined: `target_ready`=0 throughout SLEW, as above.

Decomposition:
- Shared package holds:
  - FREQ_W=28, FINE_W=18, STEP_W=16;
  - FINE_MAX/FINE_MIN constants;
  - state enum {IDLE, SLEW}.
- One natural sub-module: cav4_freq_sat, a signed 29→18 saturator with clip flag, reusable by other fine paths.

Test Plan:
- DF_SCALE=2, STEP_DIV=4, from reset, accept `target`=1000, `step`=300 at edge 0 → `fine`=1000 after edge 0. `coarse_freq`=300/600/900/1000 at edges 4/8/12/16; `fine`=700/400/100/0. `done` high only after edge 16; `busy` high for edges 0..15.
- Accept `target`=−200000, `step`=65535 → `fine`=−131072, `fine_sat`=1. `coarse_freq`=−65535, −131070 at steps 1–2; `fine_sat` clears at step 2 (`fine`=−68930). Step 3 lands at −196605; step 4 reaches −200000 with `done`.
- `step`=0, `target`=12345 → single step at edge STEP_DIV: `coarse_freq`=12345, `fine`=0, `done`=1.
- `target_valid` held during SLEW (macro undefined) → `target_ready`=0, target ignored until `done`, then accepted the next cycle.
- Assert `rst_n`=0 mid-slew → `coarse_freq`, `fine`, `busy` and `done` are 0 immediately (asynchronous). After release, `target_ready`=1 and no `done` pulse occurs.
- CAV4_FREQ_RETARGET_EN: retarget to 0 at `coarse_freq`=600 mid-ramp to 1000 → ramp reverses: `coarse_freq`=300, then 0 with a single `done`.
